// File: rtl/ext_pkg.sv
// Shared constants for the immediate extension pipeline: extension-mode encodings.
package ext_pkg;

    localparam int EOP_W = 3;

    typedef enum logic [EOP_W-1:0] {
        EXT_SIGN = 3'b000,
        EXT_ZERO = 3'b001,
        EXT_LUI  = 3'b010,
        EXT_BR   = 3'b011,
        EXT_SHV  = 3'b100
    } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// Combinational extension datapath: mode select, shifts and optional overflow flag.
// Overflow detection is built only when EXT_OVF_FLAG_EN is defined.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [EOP_W-1:0]  eop,
    input  logic [SH_W-1:0]   shamt,
    output logic [DATA_W-1:0] data,
    output logic              ovf
);

    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] shv;

    always_comb begin
        sx   = DATA_W'($signed(imm));
        shv  = '0;
        data = '0;
        ovf  = 1'b0;
        case (ext_op_e'(eop))
            EXT_SIGN: data = sx;
            EXT_ZERO: data = DATA_W'(imm);
            EXT_LUI:  data = DATA_W'(imm) << (DATA_W - IMM_W);
            EXT_BR: begin
                shv  = sx << 2;
                data = shv;
`ifdef EXT_OVF_FLAG_EN
                // shifting back must reproduce the operand if nothing significant was lost
                ovf  = (DATA_W'($signed(shv) >>> 2) != sx);
`endif
            end
            EXT_SHV: begin
                shv  = sx << shamt;
                data = shv;
`ifdef EXT_OVF_FLAG_EN
                ovf  = (DATA_W'($signed(shv) >>> shamt) != sx);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Two-stage valid/ready immediate extension pipeline: s0 holds request fields,
// s1 holds the extended result. Optional overflow flag via EXT_OVF_FLAG_EN.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [EOP_W-1:0]  eop,
    input  logic [SH_W-1:0]   shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [EOP_W-1:0] eop;
        logic [SH_W-1:0]  shamt;
    } s0_t;

    // vld_pipe[0] = s0_valid, vld_pipe[1] = s1_valid
    logic [1:0]        vld_pipe;
    s0_t               s0;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ovf;
    logic [DATA_W-1:0] core_data;
    logic              core_ovf;
    logic              s1_load;
    logic              in_fire;
    logic              out_fire;

    assign s1_load   = vld_pipe[0] && (!vld_pipe[1] || out_ready);
    assign in_ready  = !vld_pipe[0] || !vld_pipe[1] || out_ready;
    assign in_fire   = in_valid && in_ready;
    // no downstream handshake may complete during a reset cycle
    assign out_valid = vld_pipe[1] && !reset;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = s1_data;
    assign out_ovf   = s1_ovf;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_core (
        .imm   (s0.imm),
        .eop   (s0.eop),
        .shamt (s0.shamt),
        .data  (core_data),
        .ovf   (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s0       <= '0;
            s1_data  <= '0;
            s1_ovf   <= 1'b0;
        end else begin
            if (in_fire) begin
                s0.imm   <= imm;
                s0.eop   <= eop;
                s0.shamt <= shamt;
            end
            vld_pipe[0] <= in_fire || (vld_pipe[0] && !s1_load);
            if (s1_load) begin
                s1_data <= core_data;
                s1_ovf  <= core_ovf;
            end
            vld_pipe[1] <= s1_load || (vld_pipe[1] && !out_fire);
        end
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, two-stage pipelined immediate extension unit for the datapath decode/execute boundary. It widens an IMM_W-bit immediate to DATA_W bits in one of five modes: sign, zero, upper-load, sign-shift-by-2 and variable sign-shift. Input and output use valid/ready handshakes, so the unit can sit between decode and a stallable execute stage at full throughput.

## Interface
Parameters:
- IMM_W, 16, immediate width; IMM_W ≥ 2.
- DATA_W, 32, result width; DATA_W ≥ IMM_W.
- SH_W, $clog2(DATA_W), width of the variable shift amount.

Ports:
- clk  input  1  clock; all state on the rising edge.
- reset  input  1  synchronous, active-high; clears both pipeline stages.
- in_valid  input  1  the upstream request is valid.
- in_ready  output  1  the unit accepts a request this cycle.
- imm  input  IMM_W  immediate.
- eop  input  3  extension mode.
- shamt  input  SH_W  shift amount, used by mode 100 only.
- out_valid  output  1  the result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  extended result.
- out_ovf  output  1  shifted-out significant bits flag (see Configuration).

## Operation
- eop 000: sign-extend imm to DATA_W.
- eop 001: zero-extend.
- eop 010: {imm, (DATA_W−IMM_W) zeros}. If DATA_W == IMM_W, the result is imm.
- eop 011: sign-extend, then shift left by 2; low 2 bits 0; upper bits drop at DATA_W.
- eop 100: sign-extend, then shift left by shamt; bits beyond DATA_W are discarded.
- eop 101–111: out_data = 0; out_ovf = 0.
- Stage 0 (s0) registers {imm, eop, shamt} plus s0_valid.
- Stage 1 (s1) registers the computed result plus s1_valid.
- The computation lives between s0 and s1.
- s1_load = s0_valid && (!s1_valid || out_ready).
- in_ready = !s0_valid || !s1_valid || out_ready. This is a combinational path from out_ready.
- Input handshake fires when in_valid && in_ready. Output handshake fires when out_valid && out_ready.
- out_valid = s1_valid. out_data and out_ovf come directly from the s1 registers.
- While out_valid && !out_ready, out_data and out_ovf are held stable.

## Timing
- Reset values: s0_valid = 0, s1_valid = 0, out_valid = 0, out_data = 0, out_ovf = 0. in_ready = 1 in the cycle after reset.
- Latency: a request accepted at edge k appears with out_valid = 1 after edge k+1.
- Throughput: one result per cycle while out_ready = 1.
- Both stages full and out_ready = 0: in_ready = 0 and nothing moves.
- Both stages full and out_ready = 1 with a new input: s1 takes s0, and s0 takes the new input, in the same edge.
- s1 drains while s0 is empty: s1_valid falls after the output handshake unless s0 loads s1 on the same edge.
- Reset asserted mid-operation: both in-flight items are discarded. No output handshake occurs in a cycle where reset is high.
- eop decode uses the registered s0 copy only. Changing inputs while in_ready = 0 has no effect.

## Configuration
- EXT_OVF_FLAG_EN defined: out_ovf = 1 for eop 011 or 100 when any bit shifted out above DATA_W−1, or the new MSB, differs from the sign of the sign-extended value. Otherwise out_ovf = 0.
- Macro undefined: out_ovf is tied to 0, no overflow logic is synthesised, and the port remains present.

## Structure
- Package ext_pkg holds:
  - EOp constants EXT_SIGN = 3'b000, EXT_ZERO = 3'b001, EXT_LUI = 3'b010, EXT_BR = 3'b011, EXT_SHV = 3'b100.
  - The eop width constant EOP_W = 3.
- Sub-module ext_core: purely combinational mode/shift/overflow datapath from the s0 fields to the result. It is instantiated once between the stages.
- ext_pipe contains only the two stage registers and the handshake logic.

## Test plan
- Defaults, out_ready = 1: the following are accepted on consecutive cycles and produce results on consecutive cycles with 2-cycle latency:
  - imm 16'h8004, eop 000 → 32'hFFFF8004.
  - eop 001 → 32'h00008004.
  - eop 010 → 32'h80040000.
  - eop 011 → 32'hFFFE0010.
- eop 100, imm 16'h0001, shamt 31 → 32'h80000000. out_ovf = 1 with EXT_OVF_FLAG_EN, 0 without.
- Backpressure: send 3 requests with out_ready = 0. Expect in_ready low after 2 accepts and out_data stable. Raise out_ready: all 3 results emerge in order, one per cycle.
- eop 111, imm 16'hFFFF → out_data 0, out_ovf 0.
- Assert reset for 1 cycle with both stages full: the next cycle shows out_valid = 0, out_data = 0, in_ready = 1, and no stale result appears afterwards.
- IMM_W = 12, DATA_W = 64, eop 000, imm 12'h800 → 64'hFFFFFFFFFFFFF800. eop 010 → 12'h800 placed in bits 63:52.
